// File: rtl/marian_fpga_pkg.sv
// Shared types and helpers for the Marian FPGA glue logic.
// Holds the invalidation line type and line alignment helper.
package marian_fpga_pkg;

  localparam int unsigned InvalArbNumReq = 2;
  localparam int unsigned InvalAddrWidth = 64;

  typedef logic [InvalAddrWidth-1:0] inval_line_t;

  function automatic inval_line_t line_align(
    input inval_line_t addr,
    input int unsigned line_width
  );
    inval_line_t mask;
    mask = inval_line_t'(line_width) - inval_line_t'(1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/inval_req_arbiter_out_reg.sv
// One-entry output register for the L1 invalidation port.
// Loads when empty or draining in the same cycle.
module inval_out_reg
  import marian_fpga_pkg::*;
#(
  parameter int unsigned AddrWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 can_load_o,
  output logic                 valid_o,
  output logic [AddrWidth-1:0] addr_o,
  input  logic                 ready_i
);

  logic                 valid_q, valid_d;
  logic [AddrWidth-1:0] addr_q, addr_d;

  assign can_load_o = !valid_q || ready_i;
  assign valid_o    = valid_q;
  assign addr_o     = addr_q;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: rtl/inval_req_arbiter.sv
// Round-robin arbiter sharing the L1 invalidation port.
// Optional INVAL_ARB_MERGE_EN drops requests hitting the held line.
module inval_req_arbiter
  import marian_fpga_pkg::*;
#(
  parameter int unsigned NumReq      = InvalArbNumReq,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              en_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]  req_addr_i,
  input  logic [NumReq-1:0]                 req_valid_i,
  output logic [NumReq-1:0]                 req_ready_o,
  output logic [AddrWidth-1:0]              inval_addr_o,
  output logic                              inval_valid_o,
  input  logic                              inval_ready_i,
`ifdef INVAL_ARB_MERGE_EN
  output logic [31:0]                       merge_cnt_o,
`endif
  output logic                              busy_o
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [PtrW:0] NumReqW = (PtrW+1)'(NumReq);

  logic [PtrW-1:0]      ptr_q;
  logic [PtrW-1:0]      win;
  logic                 found;
  logic [AddrWidth-1:0] win_addr;
  logic [AddrWidth-1:0] win_line;
  inval_line_t          aligned_full;
  logic                 can_load;
  logic                 grant;
  logic                 load;
  logic                 merge_hit;

  always_comb begin
    logic [PtrW:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      idx = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (idx >= NumReqW) idx = idx - NumReqW;
      if (!found && req_valid_i[idx[PtrW-1:0]]) begin
        found = 1'b1;
        win   = idx[PtrW-1:0];
      end
    end
  end

  assign win_addr     = req_addr_i[win];
  assign aligned_full = line_align(inval_line_t'(win_addr), L1LineWidth);
  assign win_line     = aligned_full[AddrWidth-1:0];

`ifdef INVAL_ARB_MERGE_EN
  logic [31:0] merge_cnt_q, merge_cnt_d;

  // Same line already pending: grant the source but keep the held entry.
  assign merge_hit = inval_valid_o && !inval_ready_i
                   && (win_line == inval_addr_o);

  always_comb begin
    merge_cnt_d = merge_cnt_q;
    if (grant && merge_hit && (merge_cnt_q != 32'hFFFF_FFFF))
      merge_cnt_d = merge_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) merge_cnt_q <= '0;
    else       merge_cnt_q <= merge_cnt_d;
  end

  assign merge_cnt_o = merge_cnt_q;
`else
  assign merge_hit = 1'b0;
`endif

  assign grant = en_i && !rst_i && found && (can_load || merge_hit);
  assign load  = grant && !merge_hit;

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[win] = 1'b1;
  end

  generate
    if (NumReq == 1) begin : g_single
      assign ptr_q = '0;
    end else begin : g_rr
      logic [PtrW-1:0] ptr_r, ptr_d;

      always_comb begin
        ptr_d = ptr_r;
        if (grant) begin
          if ({1'b0, win} == NumReqW - (PtrW+1)'(1)) ptr_d = '0;
          else                                        ptr_d = win + PtrW'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) ptr_r <= '0;
        else       ptr_r <= ptr_d;
      end

      assign ptr_q = ptr_r;
    end
  endgenerate

  inval_out_reg #(
    .AddrWidth (AddrWidth)
  ) u_out_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .addr_i     (win_line),
    .can_load_o (can_load),
    .valid_o    (inval_valid_o),
    .addr_o     (inval_addr_o),
    .ready_i    (inval_ready_i)
  );

  assign busy_o = inval_valid_o;

endmodule
